// File: rtl/fp16_pkg.sv
// Purpose: constants and field layout for IEEE-754 binary16 values, plus the
//          latency of the pipelined adder that the sequencer wraps.
// Ports:   none (package).
package fp16_pkg;

    localparam int FP16_W   = 16;
    localparam int EXP_W    = 5;
    localparam int MAN_W    = 10;
    localparam int EXP_BIAS = 15;
    localparam int ADD_LAT  = 3;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp16_t;

endpackage

// File: rtl/fp16_add_sequencer_if.sv
// Purpose: operand-in / result-out stream bundle of the fp16 add sequencer.
// Signals: in_valid/in_ready/in_x/in_y/in_tag  - operand pair stream
//          out_valid/out_ready/out_z/out_tag   - result stream
// Modports: slave  - the sequencer (accepts operands, produces results)
//           master - the producer/consumer side
interface fp16_add_sequencer_if #(
    parameter int TAG_W = 4
);
    import fp16_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [FP16_W-1:0] in_x;
    logic [FP16_W-1:0] in_y;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [FP16_W-1:0] out_z;
    logic [TAG_W-1:0]  out_tag;

    modport slave (
        input  in_valid, in_x, in_y, in_tag, out_ready,
        output in_ready, out_valid, out_z, out_tag
    );

    modport master (
        output in_valid, in_x, in_y, in_tag, out_ready,
        input  in_ready, out_valid, out_z, out_tag
    );

endinterface

// File: rtl/fp16_result_fifo.sv
// Purpose: show-ahead synchronous FIFO holding {sum, tag} results.
// Ports:   clk, reset (async, active-high)
//          wr_en/wr_data  - push one entry (caller guarantees space)
//          rd_en          - pop the head entry when valid
//          rd_data        - head entry, zero while empty
//          valid          - FIFO not empty
//          count          - number of stored entries
module fp16_result_fifo #(
    parameter  int WIDTH = 20,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    assign valid = (count_q != '0);
    assign pop   = rd_en & valid;
    assign count = count_q;
    // Gating keeps the outputs at zero whenever nothing is buffered.
    assign rd_data = valid ? mem_q[rd_ptr_q] : '0;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fp16_add_sequencer.sv
// Purpose: issue/collect wrapper around the 3-stage fp16 adder. Operand pairs
//          are registered and driven to the adder, a valid/tag pipe follows
//          them through the adder, and results land in a credit-protected
//          FIFO so nothing is dropped while the consumer stalls.
// Ports:   clk, reset (async, active-high)
//          bus          - operand/result streams (slave side)
//          add_x/add_y  - operands to the adder
//          add_counter  - adder counter input, tied to zero
//          add_z        - adder result, aligned with the last pipe slot
//          busy         - an operation is in issue, pipe or FIFO
module fp16_add_sequencer
    import fp16_pkg::*;
#(
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ADD_LAT    = fp16_pkg::ADD_LAT
) (
    input  logic                clk,
    input  logic                reset,
    fp16_add_sequencer_if.slave bus,
    output logic [FP16_W-1:0]   add_x,
    output logic [FP16_W-1:0]   add_y,
    output logic [2:0]          add_counter,
    input  logic [FP16_W-1:0]   add_z,
    output logic                busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CRD_W = $clog2(FIFO_DEPTH + ADD_LAT + 2) + 1;

    typedef logic [TAG_W-1:0] tag_t;

    fp16_t              iss_x_q, iss_x_d;
    fp16_t              iss_y_q, iss_y_d;
    tag_t               iss_tag_q, iss_tag_d;
    logic               iss_v_q, iss_v_d;
    logic [ADD_LAT-1:0] pv_q, pv_d;
    tag_t               pt_q [ADD_LAT];
    tag_t               pt_d [ADD_LAT];
    logic               in_ready_q, in_ready_d;

    logic                    accept;
    logic                    fifo_wr;
    logic                    fifo_pop;
    logic                    fifo_valid;
    logic [CNT_W-1:0]        fifo_count;
    logic [FP16_W+TAG_W-1:0] fifo_rd_data;
    logic [CRD_W-1:0]        credit_used;

    assign accept   = bus.in_valid & in_ready_q;
    assign fifo_wr  = pv_q[ADD_LAT-1];
    assign fifo_pop = fifo_valid & bus.out_ready;

    always_comb begin
        iss_v_d   = accept;
        iss_x_d   = '0;
        iss_y_d   = '0;
        iss_tag_d = '0;
        if (accept) begin
            iss_x_d   = bus.in_x;
            iss_y_d   = bus.in_y;
            iss_tag_d = bus.in_tag;
        end

        pv_d    = {pv_q[ADD_LAT-2:0], iss_v_q};
        pt_d[0] = iss_tag_q;
        for (int i = 1; i < ADD_LAT; i++) begin
            pt_d[i] = pt_q[i-1];
        end

        // in_ready is registered from next-state occupancy, which equals the
        // credit rule evaluated on the registered state one cycle later. A
        // pop therefore frees its credit only from the following cycle.
        credit_used = CRD_W'(fifo_count) + CRD_W'(fifo_wr) - CRD_W'(fifo_pop)
                    + CRD_W'(iss_v_d);
        for (int i = 0; i < ADD_LAT; i++) begin
            credit_used = credit_used + CRD_W'(pv_d[i]);
        end
        in_ready_d = (credit_used < CRD_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_v_q    <= 1'b0;
            iss_x_q    <= '0;
            iss_y_q    <= '0;
            iss_tag_q  <= '0;
            pv_q       <= '0;
            for (int i = 0; i < ADD_LAT; i++) begin
                pt_q[i] <= '0;
            end
            in_ready_q <= 1'b0;
        end else begin
            iss_v_q    <= iss_v_d;
            iss_x_q    <= iss_x_d;
            iss_y_q    <= iss_y_d;
            iss_tag_q  <= iss_tag_d;
            pv_q       <= pv_d;
            pt_q       <= pt_d;
            in_ready_q <= in_ready_d;
        end
    end

    fp16_result_fifo #(
        .WIDTH (FP16_W + TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data ({add_z, pt_q[ADD_LAT-1]}),
        .rd_en   (bus.out_ready),
        .rd_data (fifo_rd_data),
        .valid   (fifo_valid),
        .count   (fifo_count)
    );

    assign bus.in_ready               = in_ready_q;
    assign bus.out_valid              = fifo_valid;
    assign {bus.out_z, bus.out_tag}   = fifo_rd_data;
    assign add_x                      = iss_x_q;
    assign add_y                      = iss_y_q;
    assign add_counter                = 3'd0;
    assign busy                       = iss_v_q | (|pv_q) | fifo_valid;

endmodule

// File: tb/tb_fp16_add_sequencer.sv
module tb_fp16_add_sequencer;

    localparam int TAG_W      = 4;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [15:0]      z;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic        clk;
    logic        reset;
    logic [15:0] add_x, add_y, add_z;
    logic [2:0]  add_counter;
    logic        busy;

    fp16_add_sequencer_if #(.TAG_W(TAG_W)) bus ();

    fp16_add_sequencer #(
        .TAG_W      (TAG_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .add_x       (add_x),
        .add_y       (add_y),
        .add_counter (add_counter),
        .add_z       (add_z),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    res_t sbq [$];
    logic [15:0] tbl [8];

    // Stand-in adder for non-negative normal operands (exact sums only).
    function automatic logic [15:0] fp16_add_model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] hi, lo;
        logic [4:0]  e;
        logic [11:0] ma, mb, s;
        int          d;
        if (a[14:0] == 15'd0) return b;
        if (b[14:0] == 15'd0) return a;
        if (b[14:10] > a[14:10]) begin hi = b; lo = a; end
        else begin hi = a; lo = b; end
        e  = hi[14:10];
        ma = {2'b01, hi[9:0]};
        mb = {2'b01, lo[9:0]};
        d  = int'(hi[14:10]) - int'(lo[14:10]);
        s  = ma + (mb >> d);
        if (s[11]) begin s = s >> 1; e = e + 5'd1; end
        return {1'b0, e, s[9:0]};
    endfunction

    logic [15:0] s0, s1, s2;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0 <= '0; s1 <= '0; s2 <= '0;
        end else begin
            s0 <= fp16_add_model(add_x, add_y);
            s1 <= s0;
            s2 <= s1;
        end
    end
    assign add_z = s2;

    function automatic real dec16(input logic [15:0] h);
        real m;
        int  e;
        if (h[14:10] == 5'd0) return 0.0;
        m = 1.0 + $itor(h[9:0]) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return m;
    endfunction

    function automatic logic [15:0] enc16(input real r);
        real m;
        int  e, man;
        if (r == 0.0) return 16'h0000;
        m = r; e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        man = $rtoi((m - 1.0) * 1024.0);
        return {1'b0, 5'(e + 15), 10'(man)};
    endfunction

    int wr_cnt   = 0;
    int ovf_viol = 0;
    int max_cnt  = 0;
    always @(posedge clk) begin
        if (int'(dut.fifo_count) > max_cnt) max_cnt <= int'(dut.fifo_count);
        if (dut.fifo_wr) wr_cnt <= wr_cnt + 1;
        if (dut.fifo_wr && int'(dut.fifo_count) == FIFO_DEPTH && !dut.fifo_pop)
            ovf_viol <= ovf_viol + 1;
    end

    // Called just after a negedge: drives inputs for the coming posedge and
    // reports whether an accept and/or a pop will happen on that edge.
    task automatic apply(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic [TAG_W-1:0] tg, input logic ordy,
                         output logic acc, output logic popd, output res_t got);
        res_t e;
        bus.in_valid  = v;
        bus.in_x      = x;
        bus.in_y      = y;
        bus.in_tag    = tg;
        bus.out_ready = ordy;
        acc = v & bus.in_ready;
        if (acc) begin
            e.z   = enc16(dec16(x) + dec16(y));
            e.tag = tg;
            sbq.push_back(e);
        end
        popd    = bus.out_valid & ordy;
        got.z   = bus.out_z;
        got.tag = bus.out_tag;
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_x = 0; bus.in_y = 0; bus.in_tag = 0; bus.out_ready = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b, required 0", bus.in_ready); end
        vectors++; if (add_x !== 16'h0) begin miscompares++; $display("FAIL reset_add_x: got %h, required 0000", add_x); end
        vectors++; if (add_y !== 16'h0) begin miscompares++; $display("FAIL reset_add_y: got %h, required 0000", add_y); end
        vectors++; if (add_counter !== 3'd0) begin miscompares++; $display("FAIL reset_add_counter: got %0d, required 0", add_counter); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
        vectors++; if (bus.out_z !== 16'h0) begin miscompares++; $display("FAIL reset_out_z: got %h, required 0000", bus.out_z); end
        vectors++; if (bus.out_tag !== 4'h0) begin miscompares++; $display("FAIL reset_out_tag: got %h, required 0", bus.out_tag); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b, required 1", bus.in_ready); end
    endtask

    task automatic test_single();
        logic acc, popd;
        res_t got, exp;
        int   first;
        apply(1'b1, 16'h3C00, 16'h3C00, 4'd5, 1'b1, acc, popd, got);
        vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL single_accept: got %b, required 1", acc); end
        first = -1;
        for (int i = 0; i < 12 && first < 0; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) first = i;
            apply(1'b0, 16'h0, 16'h0, 4'd0, 1'b1, acc, popd, got);
            if (popd) begin
                exp = sbq.pop_front();
                vectors++; if (got !== exp) begin miscompares++; $display("FAIL single_scoreboard: got %h/%h, required %h/%h", got.z, got.tag, exp.z, exp.tag); end
                vectors++; if (got !== {16'h4000, 4'd5}) begin miscompares++; $display("FAIL single_value: got %h/%h, required 4000/5", got.z, got.tag); end
            end
        end
        vectors++; if (first != 4) begin miscompares++; $display("FAIL single_latency: got %0d clocks, required 4", first); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic        acc, popd;
        res_t        got, exp;
        logic [15:0] bx [3];
        logic [15:0] by [3];
        res_t        bz [3];
        int          pidx [3];
        int          n;
        bx[0] = 16'h3E00; by[0] = 16'h3800; bz[0] = {16'h4000, 4'd1};
        bx[1] = 16'h0000; by[1] = 16'h0000; bz[1] = {16'h0000, 4'd2};
        bx[2] = 16'h4000; by[2] = 16'h3C00; bz[2] = {16'h4200, 4'd3};
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, bx[i], by[i], 4'(i + 1), 1'b1, acc, popd, got);
            vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL b2b_accept%0d: got %b, required 1", i, acc); end
            @(negedge clk);
        end
        n = 0;
        for (int c = 0; c < 12; c++) begin
            apply(1'b0, 16'h0, 16'h0, 4'd0, 1'b1, acc, popd, got);
            if (popd && n < 3) begin
                exp = sbq.pop_front();
                vectors++; if (got !== exp) begin miscompares++; $display("FAIL b2b_scoreboard%0d: got %h/%h, required %h/%h", n, got.z, got.tag, exp.z, exp.tag); end
                vectors++; if (got !== bz[n]) begin miscompares++; $display("FAIL b2b_value%0d: got %h/%h, required %h/%h", n, got.z, got.tag, bz[n].z, bz[n].tag); end
                pidx[n] = c;
                n++;
            end
            @(negedge clk);
        end
        vectors++; if (n != 3) begin miscompares++; $display("FAIL b2b_count: got %0d results, required 3", n); end
        else begin
            vectors++; if (pidx[1] != pidx[0] + 1 || pidx[2] != pidx[1] + 1) begin
                miscompares++; $display("FAIL b2b_spacing: got cycles %0d,%0d,%0d, required consecutive", pidx[0], pidx[1], pidx[2]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic acc, popd;
        res_t got, exp;
        int   k, npop;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            apply(k < 6, tbl[k % 8], tbl[(k + 3) % 8], 4'(k), 1'b0, acc, popd, got);
            if (acc) k++;
            @(negedge clk);
        end
        vectors++; if (k != 4) begin miscompares++; $display("FAIL bp_accepted: got %0d, required 4", k); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_low: got %b, required 0", bus.in_ready); end
        vectors++; if (int'(dut.fifo_count) != 4) begin miscompares++; $display("FAIL bp_fifo_full: got %0d, required 4", dut.fifo_count); end
        npop = 0;
        for (int i = 0; i < 40 && npop < 6; i++) begin
            if (i == 0) begin
                vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_before_pop: got %b, required 0", bus.in_ready); end
            end
            if (i == 1) begin
                vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after_pop: got %b, required 1", bus.in_ready); end
            end
            apply(k < 6, tbl[k % 8], tbl[(k + 3) % 8], 4'(k), 1'b1, acc, popd, got);
            if (acc) k++;
            if (popd) begin
                exp = sbq.pop_front();
                vectors++; if (got !== exp) begin miscompares++; $display("FAIL bp_order%0d: got %h/%h, required %h/%h", npop, got.z, got.tag, exp.z, exp.tag); end
                npop++;
            end
            @(negedge clk);
        end
        vectors++; if (npop != 6 || k != 6) begin miscompares++; $display("FAIL bp_complete: got %0d popped %0d accepted, required 6/6", npop, k); end
    endtask

    task automatic test_random();
        logic        acc, popd, cur_v, ordy;
        logic [15:0] cx, cy;
        res_t        got, exp;
        int          sent, rcvd, cyc;
        sent = 0; rcvd = 0; cyc = 0; cur_v = 1'b0; cx = 0; cy = 0;
        while (rcvd < 1000 && cyc < 20000) begin
            if (!cur_v && sent < 1000 && $urandom_range(0, 9) < 7) begin
                cur_v = 1'b1;
                cx = tbl[$urandom_range(0, 7)];
                cy = tbl[$urandom_range(0, 7)];
            end
            ordy = ($urandom_range(0, 9) < 6);
            apply(cur_v, cx, cy, 4'(sent), ordy, acc, popd, got);
            if (acc) begin cur_v = 1'b0; sent++; end
            if (popd) begin
                vectors++;
                if (sbq.size() == 0) begin
                    miscompares++; $display("FAIL rand_extra: got %h/%h, required no result", got.z, got.tag);
                end else begin
                    exp = sbq.pop_front();
                    if (got !== exp) begin miscompares++; $display("FAIL rand_result%0d: got %h/%h, required %h/%h", rcvd, got.z, got.tag, exp.z, exp.tag); end
                end
                rcvd++;
            end
            cyc++;
            @(negedge clk);
        end
        vectors++; if (rcvd != 1000 || sbq.size() != 0) begin miscompares++; $display("FAIL rand_complete: got %0d results %0d pending, required 1000/0", rcvd, sbq.size()); end
        vectors++; if (ovf_viol != 0) begin miscompares++; $display("FAIL rand_overflow: got %0d writes into full FIFO, required 0", ovf_viol); end
        vectors++; if (max_cnt > FIFO_DEPTH) begin miscompares++; $display("FAIL rand_max_count: got %0d, required <= %0d", max_cnt, FIFO_DEPTH); end
        bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic acc, popd;
        res_t got;
        int   seen;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, tbl[i], tbl[i + 1], 4'(8 + i), 1'b1, acc, popd, got);
            vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL mr_accept%0d: got %b, required 1", i, acc); end
            @(negedge clk);
        end
        repeat (2) begin
            apply(1'b0, 16'h0, 16'h0, 4'd0, 1'b1, acc, popd, got);
            @(negedge clk);
        end
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL mr_pre_valid: got %b, required 1", bus.out_valid); end
        reset = 1'b1;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mr_out_valid: got %b, required 0", bus.out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mr_busy: got %b, required 0", busy); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL mr_in_ready: got %b, required 0", bus.in_ready); end
        vectors++; if (bus.out_z !== 16'h0 || bus.out_tag !== 4'h0) begin miscompares++; $display("FAIL mr_out_data: got %h/%h, required 0000/0", bus.out_z, bus.out_tag); end
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            apply(1'b0, 16'h0, 16'h0, 4'd0, 1'b1, acc, popd, got);
            if (bus.out_valid === 1'b1) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL mr_stale: got %0d results, required 0", seen); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mr_busy_after: got %b, required 0", busy); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL mr_ready_after: got %b, required 1", bus.in_ready); end
    endtask

    task automatic test_idle();
        logic acc, popd;
        res_t got;
        int   w0, bad;
        @(negedge clk);
        w0 = wr_cnt; bad = 0;
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 16'h0, 16'h0, 4'd0, 1'b1, acc, popd, got);
            vectors++;
            if (add_counter !== 3'd0 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_cycle%0d: got counter=%0d out_valid=%b busy=%b, required 0/0/0", i, add_counter, bus.out_valid, busy);
            end
            @(negedge clk);
        end
        vectors++; if (wr_cnt != w0) begin miscompares++; $display("FAIL idle_writes: got %0d FIFO writes, required 0", wr_cnt - w0); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = 16'h0000; tbl[1] = 16'h3800; tbl[2] = 16'h3C00; tbl[3] = 16'h3E00;
        tbl[4] = 16'h4000; tbl[5] = 16'h4200; tbl[6] = 16'h4400; tbl[7] = 16'h3400;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_mid_reset();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
